// File: rtl/gpio_irq_if.sv
// APB slave bus bundle for the GPIO block: 16-bit byte address, 32-bit data.
// Handshake: a transfer is the setup cycle (psel) followed by an access cycle (psel & penable); pready is always 1.
interface gpio_irq_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/gpio_irq.sv
// APB GPIO with atomic output updates, synchronised/debounced inputs and
// sticky W1C edge interrupt status driving one registered level irq.
module gpio_irq #(
    parameter int N_PADS      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    gpio_irq_if.slave         apbs,
    output logic [N_PADS-1:0] padout,
    output logic [N_PADS-1:0] padoe,
    input  logic [N_PADS-1:0] padin,
    output logic              irq
);
    localparam logic [15:0] A_OUT  = 16'h00;
    localparam logic [15:0] A_SET  = 16'h04;
    localparam logic [15:0] A_CLR  = 16'h08;
    localparam logic [15:0] A_XOR  = 16'h0C;
    localparam logic [15:0] A_DIR  = 16'h10;
    localparam logic [15:0] A_IN   = 16'h14;
    localparam logic [15:0] A_EN   = 16'h18;
    localparam logic [15:0] A_RISE = 16'h1C;
    localparam logic [15:0] A_FALL = 16'h20;
    localparam logic [15:0] A_STAT = 16'h24;
    localparam logic [15:0] A_DEB  = 16'h28;
    localparam logic [DEBOUNCE_W-1:0] ONE_D = 1;

    logic [N_PADS-1:0]     out_q, dir_q, en_q, rise_q, fall_q, stat_q;
    logic [DEBOUNCE_W-1:0] deb_q;
    logic [N_PADS-1:0]     sync_q [SYNC_STAGES];
    logic [DEBOUNCE_W-1:0] cnt_q  [N_PADS];
    logic [N_PADS-1:0]     f_q, fd_q;
    logic                  irq_q;

    logic              addr_ok, access, wr;
    logic [N_PADS-1:0] wdata, synced, rise, fall, clr;
    logic [31:0]       rd;
    logic              unused_bits;

    assign addr_ok = (apbs.paddr[1:0] == 2'b00) && (apbs.paddr <= A_DEB);
    assign access  = apbs.psel & apbs.penable;
    assign wr      = access & apbs.pwrite & addr_ok;
    assign wdata   = apbs.pwdata[N_PADS-1:0];
    assign unused_bits = ^apbs.pwdata;

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = f_q & ~fd_q;
    assign fall   = ~f_q & fd_q;
    assign clr    = (wr && apbs.paddr == A_STAT) ? wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= padin;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // A pin's filtered level flips only after the synced level has disagreed for DEBOUNCE consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q  <= '0;
            fd_q <= '0;
            for (int i = 0; i < N_PADS; i++) cnt_q[i] <= '0;
        end else begin
            fd_q <= f_q;
            for (int i = 0; i < N_PADS; i++) begin
                if (deb_q == '0) begin
                    f_q[i]   <= synced[i];
                    cnt_q[i] <= '0;
                end else if (synced[i] == f_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= deb_q - ONE_D) begin
                    f_q[i]   <= ~f_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + ONE_D;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            dir_q  <= '0;
            en_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            deb_q  <= '0;
        end else if (wr) begin
            case (apbs.paddr)
                A_OUT:   out_q  <= wdata;
                A_SET:   out_q  <= out_q | wdata;
                A_CLR:   out_q  <= out_q & ~wdata;
                A_XOR:   out_q  <= out_q ^ wdata;
                A_DIR:   dir_q  <= wdata;
                A_EN:    en_q   <= wdata;
                A_RISE:  rise_q <= wdata;
                A_FALL:  fall_q <= wdata;
                A_DEB:   deb_q  <= apbs.pwdata[DEBOUNCE_W-1:0];
                default: ;
            endcase
        end
    end

    // New edges are OR-ed in after the clear so a coincident edge keeps its bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            stat_q <= (stat_q & ~clr) | (rise & rise_q) | (fall & fall_q);
            irq_q  <= |(stat_q & en_q);
        end
    end

    always_comb begin
        rd = '0;
        if (apbs.psel && addr_ok) begin
            case (apbs.paddr)
                A_OUT:   rd[N_PADS-1:0]     = out_q;
                A_DIR:   rd[N_PADS-1:0]     = dir_q;
                A_IN:    rd[N_PADS-1:0]     = f_q;
                A_EN:    rd[N_PADS-1:0]     = en_q;
                A_RISE:  rd[N_PADS-1:0]     = rise_q;
                A_FALL:  rd[N_PADS-1:0]     = fall_q;
                A_STAT:  rd[N_PADS-1:0]     = stat_q;
                A_DEB:   rd[DEBOUNCE_W-1:0] = deb_q;
                default: rd = '0;
            endcase
        end
    end

    assign apbs.prdata  = rd;
    assign apbs.pready  = 1'b1;
    assign apbs.pslverr = access & ~addr_ok;
    assign padout       = out_q;
    assign padoe        = dir_q;
    assign irq          = irq_q;
endmodule
